ram_arbiter: RTL

- Shares the single-port 64K main block RAM among three requesters: the 65C02 CPU, the text-mode video character fetcher and the SD-card DMA engine.
- Sits between the address decoder/CPU and the RAM instance, taking over the RAM's address, strobe, direction and data pins.
- Grants at most one access per clock. The CPU is stalled through its Rdy pin when it loses arbitration.
- Per-requester wait counters bound the latency seen by video and DMA.

---
 rtl/ram_arbiter_if.sv | 54 +++++
 rtl/ram_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the main-RAM arbiter, its three requesters and the RAM instance.
// slave = arbiter side, master = requesters/RAM side.
interface ram_arbiter_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              cpu_cs_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic              cpu_rwn_i;
    logic [7:0]        cpu_wdata_i;
    logic [7:0]        cpu_rdata_o;
    logic              cpu_rdy_o;

    logic              vid_req_i;
    logic [ADDR_W-1:0] vid_addr_i;
    logic              vid_ack_o;
    logic [7:0]        vid_rdata_o;
    logic              vid_valid_o;

    logic              dma_req_i;
    logic              dma_we_i;
    logic [ADDR_W-1:0] dma_addr_i;
    logic [7:0]        dma_wdata_i;
    logic              dma_ack_o;
    logic [7:0]        dma_rdata_o;
    logic              dma_valid_o;

    logic              ram_cs_o;
    logic              ram_rwn_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic [7:0]        ram_wdata_o;
    logic [7:0]        ram_rdata_i;

    modport slave (
        input  cpu_cs_i, cpu_addr_i, cpu_rwn_i, cpu_wdata_i,
        output cpu_rdata_o, cpu_rdy_o,
        input  vid_req_i, vid_addr_i,
        output vid_ack_o, vid_rdata_o, vid_valid_o,
        input  dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
        output dma_ack_o, dma_rdata_o, dma_valid_o,
        output ram_cs_o, ram_rwn_o, ram_addr_o, ram_wdata_o,
        input  ram_rdata_i
    );

    modport master (
        output cpu_cs_i, cpu_addr_i, cpu_rwn_i, cpu_wdata_i,
        input  cpu_rdata_o, cpu_rdy_o,
        output vid_req_i, vid_addr_i,
        input  vid_ack_o, vid_rdata_o, vid_valid_o,
        output dma_req_i, dma_we_i, dma_addr_i, dma_wdata_i,
        input  dma_ack_o, dma_rdata_o, dma_valid_o,
        input  ram_cs_o, ram_rwn_o, ram_addr_o, ram_wdata_o,
        output ram_rdata_i
    );
endinterface

// File: rtl/ram_arbiter.sv
// Single-port main RAM arbiter for CPU, video character fetch and SD DMA.
// One grant per clock; wait counters promote video/DMA above the CPU when starved.
module ram_arbiter #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned VID_MAX_WAIT = 4,
    parameter int unsigned DMA_MAX_WAIT = 16,
    parameter int unsigned CNT_W        = 5
) (
    input logic          clk_i,
    input logic          rst_i,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {OwnNone, OwnCpu, OwnVid, OwnDma} owner_e;

    owner_e           owner_q, owner_d;
    logic             owner_rd_q, owner_rd_d;
    logic [CNT_W-1:0] vid_wait_q, vid_wait_d;
    logic [CNT_W-1:0] dma_wait_q, dma_wait_d;
    logic [7:0]       cpu_hold_q, vid_rdata_q, dma_rdata_q;
    logic             vid_valid_q, dma_valid_q;
    logic             vid_urgent, dma_urgent;

    assign vid_urgent = bus.vid_req_i && (vid_wait_q >= CNT_W'(VID_MAX_WAIT));
    assign dma_urgent = bus.dma_req_i && (dma_wait_q >= CNT_W'(DMA_MAX_WAIT));

    always_comb begin
        owner_d = OwnNone;
        if (!rst_i) begin
            if (vid_urgent)             owner_d = OwnVid;
            else if (dma_urgent)        owner_d = OwnDma;
            else if (bus.cpu_cs_i)      owner_d = OwnCpu;
            else if (bus.vid_req_i)     owner_d = OwnVid;
            else if (bus.dma_req_i)     owner_d = OwnDma;
        end
    end

    always_comb begin
        bus.ram_cs_o    = 1'b0;
        bus.ram_rwn_o   = 1'b1;
        bus.ram_addr_o  = '0;
        bus.ram_wdata_o = 8'h00;
        owner_rd_d      = 1'b0;
        case (owner_d)
            OwnCpu: begin
                bus.ram_cs_o    = 1'b1;
                bus.ram_rwn_o   = bus.cpu_rwn_i;
                bus.ram_addr_o  = bus.cpu_addr_i;
                bus.ram_wdata_o = bus.cpu_wdata_i;
                owner_rd_d      = bus.cpu_rwn_i;
            end
            OwnVid: begin
                bus.ram_cs_o   = 1'b1;
                bus.ram_addr_o = bus.vid_addr_i;
                owner_rd_d     = 1'b1;
            end
            OwnDma: begin
                bus.ram_cs_o    = 1'b1;
                bus.ram_rwn_o   = ~bus.dma_we_i;
                bus.ram_addr_o  = bus.dma_addr_i;
                bus.ram_wdata_o = bus.dma_wdata_i;
                owner_rd_d      = ~bus.dma_we_i;
            end
            default: ;
        endcase
    end

    // Counters saturate rather than wrap so a starved requester stays urgent.
    always_comb begin
        vid_wait_d = '0;
        dma_wait_d = '0;
        if (bus.vid_req_i && owner_d != OwnVid) begin
            vid_wait_d = (vid_wait_q == '1) ? vid_wait_q : vid_wait_q + CNT_W'(1);
        end
        if (bus.dma_req_i && owner_d != OwnDma) begin
            dma_wait_d = (dma_wait_q == '1) ? dma_wait_q : dma_wait_q + CNT_W'(1);
        end
    end

    assign bus.vid_ack_o   = (owner_d == OwnVid);
    assign bus.dma_ack_o   = (owner_d == OwnDma);
    assign bus.cpu_rdy_o   = rst_i | ~(bus.cpu_cs_i & (owner_d != OwnCpu));
    assign bus.vid_valid_o = vid_valid_q & ~rst_i;
    assign bus.dma_valid_o = dma_valid_q & ~rst_i;
    assign bus.vid_rdata_o = vid_rdata_q;
    assign bus.dma_rdata_o = dma_rdata_q;
    assign bus.cpu_rdata_o = (owner_q == OwnCpu && owner_rd_q) ? bus.ram_rdata_i : cpu_hold_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q     <= OwnNone;
            owner_rd_q  <= 1'b0;
            vid_wait_q  <= '0;
            dma_wait_q  <= '0;
            cpu_hold_q  <= 8'h00;
            vid_rdata_q <= 8'h00;
            dma_rdata_q <= 8'h00;
            vid_valid_q <= 1'b0;
            dma_valid_q <= 1'b0;
        end else begin
            owner_q     <= owner_d;
            owner_rd_q  <= owner_rd_d;
            vid_wait_q  <= vid_wait_d;
            dma_wait_q  <= dma_wait_d;
            vid_valid_q <= (owner_q == OwnVid);
            dma_valid_q <= (owner_q == OwnDma) && owner_rd_q;
            if (owner_q == OwnVid) begin
                vid_rdata_q <= bus.ram_rdata_i;
            end
            if (owner_q == OwnDma && owner_rd_q) begin
                dma_rdata_q <= bus.ram_rdata_i;
            end
            if (owner_q == OwnCpu && owner_rd_q) begin
                cpu_hold_q <= bus.ram_rdata_i;
            end
        end
    end
endmodule
